// File: rtl/fft_data_sel.sv
// fft_data_sel: N-channel registered data selector for the FFT datapath.
// Picks one valid/ready input stream (fixed select or round-robin) and
// delivers it through a single registered output stage with backpressure.
module fft_data_sel #(
  parameter int DATA_W = 136,
  parameter int N_CH   = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       xfer_cnt
);

  logic              load_en;
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt_idx;
  logic [SEL_W-1:0]  rr_last;
  logic [DATA_W-1:0] gnt_data;
  logic              xfer;

  // Output register can take a word when empty or being drained this cycle.
  assign load_en = !out_valid || out_ready;
  assign xfer    = load_en && gnt_vld;

  // Grant: fixed select, or first valid channel after rr_last (mod N_CH).
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (!mode) begin
      // Out-of-range sel matches no channel, so it never grants.
      for (int i = 0; i < N_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      // Walk from farthest to nearest so the nearest valid channel wins.
      for (int k = N_CH; k >= 1; k--) begin
        idx = int'(rr_last) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(idx);
        end
      end
    end
  end

  // Per-channel ready: only the granted channel, only when the register can load.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = xfer && (gnt_idx == SEL_W'(i));
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Output stage, transfer counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      xfer_cnt  <= '0;
      rr_last   <= SEL_W'(N_CH - 1);
    end else if (load_en) begin
      if (gnt_vld) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_ch    <= gnt_idx;
        xfer_cnt  <= xfer_cnt + CNT_W'(1);
        if (mode) rr_last <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_data_sel.sv
// tb_fft_data_sel: directed stimulus, per-cycle behavioural model compare
// for the default instance, plus literal checks on a 3-channel instance.
module tb_fft_data_sel;

  localparam int DW = 136;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_ch;
  logic            out_ready;
  logic [CW-1:0]   xfer_cnt;

  // Small instance: 3 channels, 4-bit counter.
  logic            mode2;
  logic [1:0]      sel2;
  logic [2:0]      in_valid2;
  logic [23:0]     in_data2;
  logic [2:0]      in_ready2;
  logic            out_valid2;
  logic [7:0]      out_data2;
  logic [1:0]      out_ch2;
  logic            out_ready2;
  logic [3:0]      xfer_cnt2;

  int n_cmp = 0;
  int n_err = 0;
  bit en_cmp = 0;

  always #5 clk = ~clk;

  fft_data_sel #(.DATA_W(DW), .N_CH(N), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready),
    .xfer_cnt(xfer_cnt)
  );

  fft_data_sel #(.DATA_W(8), .N_CH(3), .SEL_W(2), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .mode(mode2), .sel(sel2), .in_valid(in_valid2),
    .in_data(in_data2), .in_ready(in_ready2), .out_valid(out_valid2),
    .out_data(out_data2), .out_ch(out_ch2), .out_ready(out_ready2),
    .xfer_cnt(xfer_cnt2)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word(input int ch);
    logic [7:0] b;
    b = 8'hA0 + 8'(ch);
    return {17{b}};
  endfunction

  task automatic set_words();
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = word(i);
  endtask

  task automatic rand_words();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < DW; j += 8) in_data[i*DW + j +: 8] = 8'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  int            m_ch    = 0;
  int            m_cnt   = 0;
  int            m_last  = N - 1;

  // Channel that should be granted, or -1 for none.
  function automatic int model_grant(input bit md, input int s, input logic [N-1:0] v, input int last);
    int best, bestd, d;
    if (!md) return (s < N && v[s]) ? s : -1;
    best = -1;
    bestd = N;
    for (int c = 0; c < N; c++) begin
      d = (c - last - 1 + 2*N) % N;   // distance after the last winner
      if (v[c] && d < bestd) begin
        best = c;
        bestd = d;
      end
    end
    return best;
  endfunction

  // Compare DUT against model mid-cycle, then advance model to the next edge.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_cnt   = 0;
      m_last  = N - 1;
    end else if (en_cmp) begin
      bit load;
      int g;
      logic [N-1:0] exp_rdy;
      load = !m_valid || out_ready;
      g = model_grant(mode, int'(sel), in_valid, m_last);
      exp_rdy = (load && g >= 0) ? N'(1 << g) : '0;
      chk("m_out_valid", 256'(out_valid), 256'(m_valid));
      chk("m_out_data", 256'(out_data), 256'(m_data));
      chk("m_out_ch", 256'(out_ch), 256'(m_ch));
      chk("m_xfer_cnt", 256'(xfer_cnt), 256'(m_cnt % 65536));
      chk("m_in_ready", 256'(in_ready), 256'(exp_rdy));
      if (load) begin
        if (g >= 0) begin
          m_valid = 1'b1;
          m_data  = in_data[g*DW +: DW];
          m_ch    = g;
          m_cnt   = (m_cnt + 1) % 65536;
          if (mode) m_last = g;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int seq6[6] = '{0, 1, 2, 3, 0, 1};
    int seq4[4] = '{1, 3, 1, 3};
    logic [DW-1:0] sv_data;
    logic [SW-1:0] sv_ch;
    logic [CW-1:0] sv_cnt;

    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    set_words();
    mode2 = 1'b0; sel2 = '0; in_valid2 = '0; in_data2 = 24'h33_22_11; out_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(0));
    chk("rst_out_ch", 256'(out_ch), 256'(0));
    chk("rst_xfer_cnt", 256'(xfer_cnt), 256'(0));
    rst = 1'b0;
    en_cmp = 1'b1;

    // Fixed mode, sel=2, all valid.
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
    @(negedge clk) chk("fix_ready", 256'(in_ready), 256'(4'b0100));
    tick();
    @(negedge clk);
    chk("fix_ch", 256'(out_ch), 256'(2));
    chk("fix_data", 256'(out_data), 256'(word(2)));
    chk("fix_valid", 256'(out_valid), 256'(1));
    chk("fix_cnt1", 256'(xfer_cnt), 256'(1));
    tick();
    @(negedge clk) chk("fix_cnt2", 256'(xfer_cnt), 256'(2));

    // Round-robin, all valid: 0,1,2,3,0,1 with no bubbles.
    do_reset();
    mode = 1'b1; in_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      chk("rr_ch", 256'(out_ch), 256'(seq6[k]));
      chk("rr_data", 256'(out_data), 256'(word(seq6[k])));
      chk("rr_valid", 256'(out_valid), 256'(1));
    end

    // Round-robin, channels 1 and 3 only, then channel 1 alone.
    do_reset();
    mode = 1'b1; in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk) chk("rr13_ch", 256'(out_ch), 256'(seq4[k]));
    end
    in_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) chk("rr1_ready", 256'(in_ready), 256'(4'b0010));
      tick();
      @(negedge clk) chk("rr1_ch", 256'(out_ch), 256'(1));
    end

    // Backpressure for 3 cycles, then release loads in the same edge.
    tick();
    out_ready = 1'b0; in_valid = 4'hF;
    rand_words();
    @(negedge clk);
    sv_data = out_data; sv_ch = out_ch; sv_cnt = xfer_cnt;
    chk("bp_ready0", 256'(in_ready), 256'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      rand_words();
      @(negedge clk);
      chk("bp_ready", 256'(in_ready), 256'(0));
      chk("bp_data", 256'(out_data), 256'(sv_data));
      chk("bp_ch", 256'(out_ch), 256'(sv_ch));
      chk("bp_cnt", 256'(xfer_cnt), 256'(sv_cnt));
    end
    tick();
    out_ready = 1'b1;
    set_words();
    @(negedge clk) chk("bp_rel_ready", 256'(in_ready), 256'(4'b0100));
    tick();
    @(negedge clk);
    chk("bp_rel_ch", 256'(out_ch), 256'(2));
    chk("bp_rel_cnt", 256'(xfer_cnt), 256'(sv_cnt + 16'd1));

    // Fixed sel=2 with channel 2 idle: no grant, output drains.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1011;
    @(negedge clk) chk("nog_ready", 256'(in_ready), 256'(0));
    tick();
    @(negedge clk) chk("nog_valid", 256'(out_valid), 256'(0));

    // Reset mid-stream, then channel 0 wins first round-robin grant.
    mode = 1'b1; in_valid = 4'hF;
    tick(); tick();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", 256'(out_valid), 256'(0));
    chk("mrst_cnt", 256'(xfer_cnt), 256'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    @(negedge clk);
    chk("mrst_ch", 256'(out_ch), 256'(0));
    chk("mrst_data", 256'(out_data), 256'(word(0)));

    // 3-channel instance: sel=3 never grants; counter wraps after 16.
    mode2 = 1'b0; sel2 = 2'd3; in_valid2 = 3'b111; out_ready2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("n3_ready", 256'(in_ready2), 256'(0));
      chk("n3_valid", 256'(out_valid2), 256'(0));
      tick();
    end
    sel2 = 2'd0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 14) begin
        @(negedge clk) chk("n3_cnt15", 256'(xfer_cnt2), 256'(15));
      end
    end
    @(negedge clk);
    chk("n3_wrap", 256'(xfer_cnt2), 256'(0));
    chk("n3_data", 256'(out_data2), 256'(8'h11));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
